dmem_image_streamer: RTL and testbench

- Downstream readout stage for the processor data memory.
- After a processed image is in data memory and the operator flips the start switch, it takes over the memory port, scans all IMG_WIDTH×IMG_HEIGHT words in raster order, and streams the low byte of each word out on a valid/ready pixel interface. This interface feeds the display/UART export path.
- When idle, the processor's data-memory port passes straight through.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/sync_edge.sv | 40 ++++
 rtl/dmem_image_streamer.sv | 156 +++++++++++++++
 tb/tb_dmem_image_streamer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg                                                               |
// | Shared types and defaults for the data-memory image streamer.          |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package dmem_pkg;

    localparam int DEF_IMG_WIDTH  = 360;
    localparam int DEF_IMG_HEIGHT = 360;
    localparam int DMEM_WORDS     = 129600;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_edge                                                              |
// | Two-flop synchronizer followed by a rising-edge pulse generator.       |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Combinational pulse keeps the edge one cycle earlier than a registered one.
    assign pulse = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/dmem_image_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_image_streamer                                                    |
// | Takes over the data-memory port and streams an image in raster order.  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module dmem_image_streamer
    import dmem_pkg::*;
#(
    parameter int          IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int          IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter logic [31:0] BASE_ADDR  = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] cpu_address,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wd,
    output logic        cpu_stall,
    output logic [31:0] mem_address,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_row_end,
    output logic        pix_last,
    output logic        done
);

    localparam int N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int IDX_W = clog2_min1(N);
    localparam int X_W   = clog2_min1(IMG_WIDTH);
    localparam int Y_W   = clog2_min1(IMG_HEIGHT);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N - 1);
    localparam logic [X_W-1:0]   c_LAST_X   = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0]   c_LAST_Y   = Y_W'(IMG_HEIGHT - 1);

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [X_W-1:0]   x_q,         x_d;
    logic [Y_W-1:0]   y_q,         y_d;
    logic [7:0]       pix_data_q,  pix_data_d;
    logic             pix_valid_q, pix_valid_d;
    logic             row_end_q,   row_end_d;
    logic             last_q,      last_d;
    logic             done_q,      done_d;

    logic w_start_pulse;
    logic w_load;
    logic w_owns;
    logic unused_rd_bits;

    sync_edge u_start_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (start),
        .pulse    (w_start_pulse)
    );

    assign w_load         = (state_q == S_STREAM) && (!pix_valid_q || pix_ready);
    assign w_owns         = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign unused_rd_bits = ^mem_rd[31:8];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        row_end_d   = row_end_q;
        last_d      = last_q;
        done_d      = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_start_pulse) begin
                    state_d = S_STREAM;
                    idx_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    done_d  = 1'b0;
                end
            end
            S_STREAM: begin
                if (w_load) begin
                    pix_data_d  = mem_rd[7:0];
                    pix_valid_d = 1'b1;
                    row_end_d   = (x_q == c_LAST_X);
                    last_d      = (idx_q == c_LAST_IDX);
                    idx_d       = (idx_q == c_LAST_IDX) ? '0 : idx_q + 1'b1;
                    if (x_q == c_LAST_X) begin
                        x_d = '0;
                        y_d = (y_q == c_LAST_Y) ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (idx_q == c_LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            row_end_q   <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            row_end_q   <= row_end_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    // Streamer keeps the port through DRAIN so the CPU cannot slip a write in.
    always_comb begin
        cpu_stall   = w_owns;
        mem_address = w_owns ? (BASE_ADDR + 32'(idx_q)) : cpu_address;
        mem_we      = w_owns ? 1'b0  : cpu_we;
        mem_wd      = w_owns ? 32'd0 : cpu_wd;
    end

    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign pix_row_end = row_end_q;
    assign pix_last    = last_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_image_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_image_streamer                                                 |
// | Directed self-checking bench for a 4x3 image at base address 16.       |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_dmem_image_streamer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] cpu_address;
    logic        cpu_we;
    logic [31:0] cpu_wd;
    logic        cpu_stall;
    logic [31:0] mem_address;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_row_end;
    logic        pix_last;
    logic        done;

    logic [31:0] mem [0:63];
    logic [9:0]  acc_q [$];
    int          last_cnt;
    int          checks;
    int          errors;

    dmem_image_streamer #(
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (3),
        .BASE_ADDR  (32'd16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cpu_address (cpu_address),
        .cpu_we      (cpu_we),
        .cpu_wd      (cpu_wd),
        .cpu_stall   (cpu_stall),
        .mem_address (mem_address),
        .mem_we      (mem_we),
        .mem_wd      (mem_wd),
        .mem_rd      (mem_rd),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_row_end (pix_row_end),
        .pix_last    (pix_last),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_address[5:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_address[5:0]] <= mem_wd;
        if (pix_valid && pix_ready) begin
            acc_q.push_back({pix_row_end, pix_last, pix_data});
            if (pix_last) last_cnt <= last_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 100 && !done; k++) tick();
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_frame(input string tag);
        logic [9:0] e;
        chk({tag, "_count"}, acc_q.size(), 32'd12);
        chk({tag, "_lastcnt"}, last_cnt, 32'd1);
        for (int i = 0; i < 12; i++) begin
            e = {(i % 4 == 3), (i == 11), 8'(i)};
            chk({tag, "_pix"}, {22'd0, acc_q[i]}, {22'd0, e});
        end
    endtask

    task automatic clear_mon();
        acc_q.delete();
        last_cnt = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_cnt = 0;
        for (int i = 0; i < 64; i++)
            mem[i] = (i >= 16 && i < 28) ? 32'h100 + 32'(i - 16) : 32'hDEAD_0000 + 32'(i);
        reset = 1'b1; start = 1'b0; pix_ready = 1'b1;
        cpu_address = 32'd0; cpu_we = 1'b0; cpu_wd = 32'd0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_data", {24'd0, pix_data}, 32'd0);
        chk("rst_row_end", {31'd0, pix_row_end}, 32'd0);
        chk("rst_last", {31'd0, pix_last}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        reset = 1'b0;
        tick();
        clear_mon();

        // Scan 1: exact timing from start edge E, with a blocked CPU write
        start = 1'b1;
        tick();
        chk("e0_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        chk("e1_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        chk("e2_stall", {31'd0, cpu_stall}, 32'd1);
        chk("e2_valid", {31'd0, pix_valid}, 32'd0);
        chk("e2_addr", mem_address, 32'd16);
        cpu_address = 32'd20; cpu_we = 1'b1; cpu_wd = 32'hAA;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("s1_valid", {31'd0, pix_valid}, 32'd1);
            chk("s1_data", {24'd0, pix_data}, 32'(i));
            chk("s1_row_end", {31'd0, pix_row_end}, {31'd0, (i % 4 == 3)});
            chk("s1_last", {31'd0, pix_last}, {31'd0, (i == 11)});
            chk("s1_done", {31'd0, done}, 32'd0);
            if (i == 4) begin
                chk("s1_gate_we", {31'd0, mem_we}, 32'd0);
                chk("s1_gate_stall", {31'd0, cpu_stall}, 32'd1);
            end
            if (i == 11) cpu_we = 1'b0;
        end
        tick();
        chk("s1_done_set", {31'd0, done}, 32'd1);
        chk("s1_valid_clr", {31'd0, pix_valid}, 32'd0);
        chk("s1_stall_clr", {31'd0, cpu_stall}, 32'd0);
        chk("s1_mem20", mem[20], 32'h104);
        chk_frame("s1");

        // Start held high: no retrigger
        for (int k = 0; k < 5; k++) tick();
        chk("hold_stall", {31'd0, cpu_stall}, 32'd0);
        chk("hold_done", {31'd0, done}, 32'd1);

        // Scan 2: new edge, ignored mid-scan edge, back-pressure at pixel 5
        start = 1'b0;
        tick(); tick(); tick();
        clear_mon();
        start = 1'b1;
        tick(); tick();
        chk("s2_done_held", {31'd0, done}, 32'd1);
        tick();
        chk("s2_done_clr", {31'd0, done}, 32'd0);
        chk("s2_stall", {31'd0, cpu_stall}, 32'd1);
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1;
        tick(); tick(); tick();
        chk("s2_pix5", {24'd0, pix_data}, 32'h05);
        pix_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_data", {24'd0, pix_data}, 32'h05);
            chk("bp_hold_valid", {31'd0, pix_valid}, 32'd1);
        end
        pix_ready = 1'b1;
        tick();
        chk("bp_next", {24'd0, pix_data}, 32'h06);
        wait_done();
        chk_frame("s2");
        tick(); tick(); tick(); tick();
        chk("s2_no_retrig", {31'd0, cpu_stall}, 32'd0);

        // Scan 3: reset at pixel 6, then a clean full frame
        start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1;
        tick(); tick(); tick();
        clear_mon();
        for (int k = 0; k < 7; k++) tick();
        chk("s3_pix6", {24'd0, pix_data}, 32'h06);
        reset = 1'b1; start = 1'b0;
        tick();
        chk("mid_rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("mid_rst_addr", mem_address, cpu_address);
        chk("mid_rst_nolast", last_cnt, 32'd0);
        reset = 1'b0;
        tick(); tick(); tick();
        clear_mon();
        start = 1'b1;
        wait_done();
        chk_frame("s4");

        // Pass-through write while done
        cpu_address = 32'd20; cpu_we = 1'b1; cpu_wd = 32'hAA;
        @(negedge clk);
        chk("pt_we", {31'd0, mem_we}, 32'd1);
        chk("pt_addr", mem_address, 32'd20);
        chk("pt_wd", mem_wd, 32'hAA);
        tick();
        cpu_we = 1'b0;
        chk("pt_mem20", mem[20], 32'hAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
